// File: rtl/host_axis_pkt_arb_pkg.sv
// Shared types and helpers for the host-side AXI-Stream packet arbiter.
package host_sim_pkg;

   typedef enum logic [0:0] {ARB, XFER} arb_st_e;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   // Width of a source index; never below one bit so a 2-source build still has a tid.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/host_axis_pkt_arb_if.sv
// AXI-Stream bundle carrying N lanes side by side; lane i's payload sits at slice [i*DW +: DW].
// Handshake: a beat moves on a lane when tvalid and tready are both 1 at posedge clk;
// tvalid never waits on tready, and the payload holds while tvalid & !tready.
interface host_axis_pkt_arb_if #(
   parameter int DW   = 512,
   parameter int N    = 1,
   parameter int ID_W = 1
);
   logic [N-1:0]        tvalid;
   logic [N-1:0]        tready;
   logic [N*DW-1:0]     tdata;
   logic [N*DW/8-1:0]   tkeep;
   logic [N-1:0]        tlast;
   logic [ID_W-1:0]     tid;

   modport master (output tvalid, tdata, tkeep, tlast, tid, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);
endinterface

// File: rtl/host_axis_pkt_arb_skid.sv
// Two-entry registered AXI-Stream slice (data + keep + last + user), one cycle of latency.
module axis_skid_buf #(
   parameter int W      = 512,
   parameter int USER_W = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_data,
   input  logic [W/8-1:0]    in_keep,
   input  logic              in_last,
   input  logic [USER_W-1:0] in_user,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic [W/8-1:0]    out_keep,
   output logic              out_last,
   output logic [USER_W-1:0] out_user
);
   localparam int E = W + W/8 + 1 + USER_W;

   logic [E-1:0] mem_q [2];
   logic [E-1:0] mem_d [2];
   logic         wr_q, wr_d, rd_q, rd_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         push, pop;

   assign in_ready  = (cnt_q != 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign {out_data, out_keep, out_last, out_user} = mem_q[rd_q];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[wr_q] = {in_data, in_keep, in_last, in_user};
         wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      // Push and pop together leave the fill level alone, keeping one beat per cycle.
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/host_axis_pkt_arb.sv
// N-source whole-packet AXI-Stream arbiter (round-robin or fixed priority) into a 2-entry skid.
// Optional per-source packet counters on port pkt_cnt when HOST_ARB_PKT_CNT_EN is defined.
module host_axis_pkt_arb
   import host_sim_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH = 512,
   parameter int NUM_SRC           = 4,
   parameter int ARB_MODE          = 0,
   localparam int SRC_W            = clog2_min1(NUM_SRC)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NUM_SRC-1:0]    src_en,
   host_axis_pkt_arb_if.slave    s_axis,
   host_axis_pkt_arb_if.master   m_axis,
   output logic                  busy
`ifdef HOST_ARB_PKT_CNT_EN
   ,
   output logic [NUM_SRC*32-1:0] pkt_cnt
`endif
);
   localparam int W  = C_AXIS_DATA_WIDTH;
   localparam int KW = W / 8;

   arb_st_e            state_q, state_d;
   logic [SRC_W-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]   pick, idx;
   logic               pick_vld;
   logic [NUM_SRC-1:0] req, tready;
   logic               sel_valid, sel_last, skid_in_ready, push;
   logic [W-1:0]       sel_data;
   logic [KW-1:0]      sel_keep;

   assign req       = s_axis.tvalid & src_en;
   assign sel_valid = s_axis.tvalid[grant_q];
   assign sel_last  = s_axis.tlast[grant_q];
   assign sel_data  = s_axis.tdata[int'(grant_q)*W +: W];
   assign sel_keep  = s_axis.tkeep[int'(grant_q)*KW +: KW];
   assign s_axis.tready = tready;
   assign busy      = (state_q == XFER);

   // Round-robin scans upward from rr_ptr+1 with wrap; fixed priority scans from index 0.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ARB_MODE == ARB_RR) idx = SRC_W'((int'(rr_ptr_q) + 1 + i) % NUM_SRC);
         else                    idx = SRC_W'(i);
         if (!pick_vld && req[idx]) begin
            pick_vld = 1'b1;
            pick     = idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      tready   = '0;
      push     = 1'b0;
      case (state_q)
         ARB: begin
            if (pick_vld) begin
               grant_d  = pick;
               rr_ptr_d = pick;
               state_d  = XFER;
            end
         end
         XFER: begin
            tready[grant_q] = skid_in_ready;
            push            = sel_valid & skid_in_ready;
            if (push && sel_last) state_d = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= ARB;
         grant_q  <= '0;
         rr_ptr_q <= SRC_W'(NUM_SRC - 1);
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   axis_skid_buf #(.W(W), .USER_W(SRC_W)) u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (push),
      .in_ready  (skid_in_ready),
      .in_data   (sel_data),
      .in_keep   (sel_keep),
      .in_last   (sel_last),
      .in_user   (grant_q),
      .out_valid (m_axis.tvalid[0]),
      .out_ready (m_axis.tready[0]),
      .out_data  (m_axis.tdata),
      .out_keep  (m_axis.tkeep),
      .out_last  (m_axis.tlast[0]),
      .out_user  (m_axis.tid)
   );

`ifdef HOST_ARB_PKT_CNT_EN
   logic [NUM_SRC-1:0][31:0] pkt_cnt_q, pkt_cnt_d;

   // Counted on the output handshake so a packet is credited once it has actually left.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (m_axis.tvalid[0] && m_axis.tready[0] && m_axis.tlast[0])
         pkt_cnt_d[m_axis.tid] = pkt_cnt_q[m_axis.tid] + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) pkt_cnt_q <= '0;
      else       pkt_cnt_q <= pkt_cnt_d;
   end

   assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_host_axis_pkt_arb.sv
// Directed bench for host_axis_pkt_arb: round-robin and fixed-priority instances share one source model.
module tb_host_axis_pkt_arb;
   import host_sim_pkg::*;

   localparam int DW = 32;
   localparam int N  = 4;
   localparam int KW = DW / 8;
   localparam int SW = 2;
   localparam int BW = SW + 1 + KW + DW;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    src_en, src_valid, src_last, src_ready;
   logic [N*DW-1:0] src_data;
   logic [N*KW-1:0] src_keep;
   logic            m_ready;
   logic            sel_fp;
   logic            busy_rr, busy_fp;
   logic            mo_valid, mo_last, mo_busy;
   logic [DW-1:0]   mo_data;
   logic [KW-1:0]   mo_keep;
   logic [SW-1:0]   mo_tid;
   logic [1:0]      mo_cnt;
`ifdef HOST_ARB_PKT_CNT_EN
   logic [N*32-1:0] pkt_cnt_rr, pkt_cnt_fp;
`endif

   host_axis_pkt_arb_if #(.DW(DW), .N(N), .ID_W(SW)) s_rr ();
   host_axis_pkt_arb_if #(.DW(DW), .N(N), .ID_W(SW)) s_fp ();
   host_axis_pkt_arb_if #(.DW(DW), .N(1), .ID_W(SW)) m_rr ();
   host_axis_pkt_arb_if #(.DW(DW), .N(1), .ID_W(SW)) m_fp ();

   assign s_rr.tvalid = sel_fp ? '0 : src_valid;
   assign s_fp.tvalid = sel_fp ? src_valid : '0;
   assign s_rr.tdata  = src_data;
   assign s_fp.tdata  = src_data;
   assign s_rr.tkeep  = src_keep;
   assign s_fp.tkeep  = src_keep;
   assign s_rr.tlast  = src_last;
   assign s_fp.tlast  = src_last;
   assign s_rr.tid    = '0;
   assign s_fp.tid    = '0;
   assign m_rr.tready = m_ready;
   assign m_fp.tready = m_ready;

   assign src_ready = sel_fp ? s_fp.tready   : s_rr.tready;
   assign mo_valid  = sel_fp ? m_fp.tvalid[0] : m_rr.tvalid[0];
   assign mo_last   = sel_fp ? m_fp.tlast[0]  : m_rr.tlast[0];
   assign mo_data   = sel_fp ? m_fp.tdata     : m_rr.tdata;
   assign mo_keep   = sel_fp ? m_fp.tkeep     : m_rr.tkeep;
   assign mo_tid    = sel_fp ? m_fp.tid       : m_rr.tid;
   assign mo_busy   = sel_fp ? busy_fp        : busy_rr;
   assign mo_cnt    = sel_fp ? dut_fp.u_skid.cnt_q : dut_rr.u_skid.cnt_q;

   host_axis_pkt_arb #(.C_AXIS_DATA_WIDTH(DW), .NUM_SRC(N), .ARB_MODE(ARB_RR)) dut_rr (
      .clk(clk), .rstn(rstn), .src_en(src_en), .s_axis(s_rr), .m_axis(m_rr), .busy(busy_rr)
`ifdef HOST_ARB_PKT_CNT_EN
      , .pkt_cnt(pkt_cnt_rr)
`endif
   );

   host_axis_pkt_arb #(.C_AXIS_DATA_WIDTH(DW), .NUM_SRC(N), .ARB_MODE(ARB_FIXED)) dut_fp (
      .clk(clk), .rstn(rstn), .src_en(src_en), .s_axis(s_fp), .m_axis(m_fp), .busy(busy_fp)
`ifdef HOST_ARB_PKT_CNT_EN
      , .pkt_cnt(pkt_cnt_fp)
`endif
   );

   // Source model state and scoreboard
   int             pkts [N][$];
   int             beat [N];
   int             pno  [N];
   logic [BW-1:0]  cap_q [$];
   int             cap_cyc [$];
   logic [BW-1:0]  exp_q [$];
   int             cyc, stall_viol, max_cnt, rp_mode;
   int             n_checks = 0;
   int             n_fail   = 0;

   function automatic logic [DW-1:0] mk_data(input int s, input int p, input int b);
      return {8'(s), 8'(p), 16'(b)};
   endfunction

   function automatic logic [KW-1:0] mk_keep(input int s, input int b);
      return KW'(b * 3 + s);
   endfunction

   task automatic add_exp(input int s, input int p, input int len);
      for (int b = 0; b < len; b++)
         exp_q.push_back({SW'(s), (b == len - 1), mk_keep(s, b), mk_data(s, p, b)});
   endtask

   task automatic engine_reset();
      for (int i = 0; i < N; i++) begin
         pkts[i].delete();
         beat[i] = 0;
         pno[i]  = 0;
      end
      cap_q.delete();
      cap_cyc.delete();
      exp_q.delete();
      stall_viol = 0;
      max_cnt    = 0;
      cyc        = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (pkts[i].size() > 0) begin
            src_valid[i]           = 1'b1;
            src_data[i*DW +: DW]   = mk_data(i, pno[i], beat[i]);
            src_keep[i*KW +: KW]   = mk_keep(i, beat[i]);
            src_last[i]            = (beat[i] == pkts[i][0] - 1);
         end else begin
            src_valid[i]           = 1'b0;
            src_data[i*DW +: DW]   = '0;
            src_keep[i*KW +: KW]   = '0;
            src_last[i]            = 1'b0;
         end
      end
      m_ready = (rp_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
   endtask

   task automatic run(input int ncyc);
      logic [N-1:0] hs;
      logic [BW:0]  cur, prev;
      logic         prev_stall;
      prev_stall = 1'b0;
      prev       = '0;
      repeat (ncyc) begin
         drive();
         @(negedge clk);
         hs  = src_valid & src_ready;
         cur = {mo_valid, mo_tid, mo_last, mo_keep, mo_data};
         if (prev_stall && cur !== prev) stall_viol++;
         prev_stall = mo_valid & !m_ready;
         prev       = cur;
         if (int'(mo_cnt) > max_cnt) max_cnt = int'(mo_cnt);
         if (mo_valid && m_ready) begin
            cap_q.push_back({mo_tid, mo_last, mo_keep, mo_data});
            cap_cyc.push_back(cyc);
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
               if (beat[i] == pkts[i][0] - 1) begin
                  void'(pkts[i].pop_front());
                  pno[i]++;
                  beat[i] = 0;
               end else begin
                  beat[i]++;
               end
            end
         end
         cyc++;
      end
   endtask

   task automatic apply_reset();
      src_valid = '0;
      src_data  = '0;
      src_keep  = '0;
      src_last  = '0;
      m_ready   = 1'b1;
      rstn      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      engine_reset();
   endtask

   task automatic test_reset();
      sel_fp    = 1'b0;
      src_en    = '1;
      src_valid = '1;
      src_last  = '0;
      src_data  = '1;
      src_keep  = '1;
      m_ready   = 1'b1;
      rstn      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks += 7;
      if (m_rr.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%b exp=0", m_rr.tvalid); end
      if (m_rr.tdata !== '0)    begin n_fail++; $display("FAIL rst_m_data got=%h exp=0", m_rr.tdata); end
      if (m_rr.tkeep !== '0)    begin n_fail++; $display("FAIL rst_m_keep got=%h exp=0", m_rr.tkeep); end
      if (m_rr.tlast !== 1'b0)  begin n_fail++; $display("FAIL rst_m_last got=%b exp=0", m_rr.tlast); end
      if (m_rr.tid !== '0)      begin n_fail++; $display("FAIL rst_m_tid got=%h exp=0", m_rr.tid); end
      if (busy_rr !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy_rr); end
      if (s_rr.tready !== '0)   begin n_fail++; $display("FAIL rst_s_ready got=%b exp=0", s_rr.tready); end
      rstn = 1'b1;
   endtask

   task automatic test_rr_four();
      apply_reset();
      rp_mode = 0;
      src_en  = '1;
      for (int i = 0; i < N; i++) begin
         pkts[i].push_back(3);
         add_exp(i, 0, 3);
      end
      run(25);
      n_checks++;
      if (cap_q.size() != 12) begin n_fail++; $display("FAIL rr4_count got=%0d exp=12", cap_q.size()); end
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rr4_beat%0d got=%h exp=%h", k, cap_q[k], exp_q[k]); end
      end
      for (int p = 0; p < 3 && cap_cyc.size() == 12; p++) begin
         n_checks++;
         if (cap_cyc[3*p+3] - cap_cyc[3*p+2] != 2) begin
            n_fail++;
            $display("FAIL rr4_gap%0d got=%0d exp=2", p, cap_cyc[3*p+3] - cap_cyc[3*p+2]);
         end
      end
      n_checks++;
      if (mo_busy !== 1'b0) begin n_fail++; $display("FAIL rr4_idle_busy got=%b exp=0", mo_busy); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      rp_mode = 0;
      src_en  = '1;
      pkts[1] = '{1, 1, 1};
      pkts[3] = '{2};
      add_exp(1, 0, 1);
      add_exp(3, 0, 2);
      add_exp(1, 1, 1);
      add_exp(1, 2, 1);
      run(20);
      n_checks++;
      if (cap_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL b2b_beat%0d got=%h exp=%h", k, cap_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_fixed_prio();
      apply_reset();
      sel_fp  = 1'b1;
      rp_mode = 0;
      src_en  = '1;
      pkts[0] = '{2, 2};
      pkts[2] = '{2, 2};
      add_exp(0, 0, 2);
      add_exp(0, 1, 2);
      add_exp(2, 0, 2);
      add_exp(2, 1, 2);
      run(20);
      n_checks++;
      if (cap_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fp_count got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL fp_beat%0d got=%h exp=%h", k, cap_q[k], exp_q[k]); end
      end
      // Source 0 masked: only source 2 may be granted even though 0 is requesting.
      cap_q.delete();
      exp_q.delete();
      src_en  = 4'b1110;
      pkts[0].push_back(1);
      pkts[2].push_back(1);
      add_exp(2, 2, 1);
      run(10);
      n_checks++;
      if (cap_q.size() != 1) begin n_fail++; $display("FAIL fp_mask_count got=%0d exp=1", cap_q.size()); end
      else begin
         n_checks++;
         if (cap_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL fp_mask_beat got=%h exp=%h", cap_q[0], exp_q[0]); end
      end
      cap_q.delete();
      exp_q.delete();
      src_en = '1;
      add_exp(0, 2, 1);
      run(8);
      n_checks++;
      if (cap_q.size() != 1) begin n_fail++; $display("FAIL fp_unmask_count got=%0d exp=1", cap_q.size()); end
      else begin
         n_checks++;
         if (cap_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL fp_unmask_beat got=%h exp=%h", cap_q[0], exp_q[0]); end
      end
      sel_fp = 1'b0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      rp_mode = 1;
      src_en  = '1;
      pkts[0].push_back(8);
      add_exp(0, 0, 8);
      run(40);
      n_checks++;
      if (cap_q.size() != 8) begin n_fail++; $display("FAIL bp_count got=%0d exp=8", cap_q.size()); end
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_beat%0d got=%h exp=%h", k, cap_q[k], exp_q[k]); end
      end
      n_checks += 2;
      if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable got=%0d exp=0", stall_viol); end
      if (max_cnt > 2)     begin n_fail++; $display("FAIL bp_skid_cnt got=%0d exp<=2", max_cnt); end
      rp_mode = 0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      rp_mode = 0;
      src_en  = '1;
      pkts[1].push_back(6);
      run(4);
      rstn      = 1'b0;
      src_valid = '0;
      src_last  = '0;
      engine_reset();
      @(posedge clk);
      #1;
      n_checks += 7;
      if (mo_valid !== 1'b0)  begin n_fail++; $display("FAIL rmid_m_valid got=%b exp=0", mo_valid); end
      if (mo_data !== '0)     begin n_fail++; $display("FAIL rmid_m_data got=%h exp=0", mo_data); end
      if (mo_keep !== '0)     begin n_fail++; $display("FAIL rmid_m_keep got=%h exp=0", mo_keep); end
      if (mo_last !== 1'b0)   begin n_fail++; $display("FAIL rmid_m_last got=%b exp=0", mo_last); end
      if (mo_tid !== '0)      begin n_fail++; $display("FAIL rmid_m_tid got=%h exp=0", mo_tid); end
      if (mo_busy !== 1'b0)   begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", mo_busy); end
      if (src_ready !== '0)   begin n_fail++; $display("FAIL rmid_s_ready got=%b exp=0", src_ready); end
      rstn = 1'b1;
      pkts[0].push_back(2);
      pkts[2].push_back(2);
      add_exp(0, 0, 2);
      add_exp(2, 0, 2);
      run(12);
      n_checks++;
      if (cap_q.size() != 4) begin n_fail++; $display("FAIL rmid_count got=%0d exp=4", cap_q.size()); end
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
         n_checks++;
         if (cap_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rmid_beat%0d got=%h exp=%h", k, cap_q[k], exp_q[k]); end
      end
   endtask

`ifdef HOST_ARB_PKT_CNT_EN
   task automatic test_pkt_cnt();
      apply_reset();
      rp_mode = 0;
      src_en  = '1;
      repeat (5) pkts[2].push_back(1);
      run(20);
      n_checks += 4;
      if (pkt_cnt_rr[64 +: 32] !== 32'd5) begin n_fail++; $display("FAIL cnt_src2 got=%0d exp=5", pkt_cnt_rr[64 +: 32]); end
      if (pkt_cnt_rr[0 +: 32] !== 32'd0)  begin n_fail++; $display("FAIL cnt_src0 got=%0d exp=0", pkt_cnt_rr[0 +: 32]); end
      if (pkt_cnt_rr[32 +: 32] !== 32'd0) begin n_fail++; $display("FAIL cnt_src1 got=%0d exp=0", pkt_cnt_rr[32 +: 32]); end
      if (pkt_cnt_rr[96 +: 32] !== 32'd0) begin n_fail++; $display("FAIL cnt_src3 got=%0d exp=0", pkt_cnt_rr[96 +: 32]); end
      force dut_rr.pkt_cnt_q = {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
      #1;
      release dut_rr.pkt_cnt_q;
      pkts[2].push_back(1);
      run(6);
      n_checks += 2;
      if (pkt_cnt_rr[64 +: 32] !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap got=%h exp=0", pkt_cnt_rr[64 +: 32]); end
      if (pkt_cnt_rr[0 +: 32] !== 32'd0)  begin n_fail++; $display("FAIL cnt_wrap_src0 got=%0d exp=0", pkt_cnt_rr[0 +: 32]); end
   endtask
`endif

   initial begin
      sel_fp    = 1'b0;
      rp_mode   = 0;
      src_en    = '1;
      src_valid = '0;
      src_data  = '0;
      src_keep  = '0;
      src_last  = '0;
      m_ready   = 1'b1;
      engine_reset();
      test_reset();
      test_rr_four();
      test_back_to_back();
      test_fixed_prio();
      test_backpressure();
      test_reset_mid();
`ifdef HOST_ARB_PKT_CNT_EN
      test_pkt_cnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "simulation time limit reached");
   end

endmodule
